hk_fetch_sequencer: RTL and testbench
=====================================

// Module: hk_fetch_sequencer
// PURPOSE
//  Controller for the H/K constant memory. On START it reads the 8 initial H words, then the 64 K
//  constants, in order, and hands each word to the compression core over a valid/ready handshake.
//  Sits between the H/K memory (HK_SELECTOR/H_ADDR/K_ADDR/RAM_DR/RDY) and the SHA-256 round core.
//  The memory is never addressed before it reports RDY.
// PARAMETERS
//  NUM_H      8    H words fetched per block (H_ADDR 0..NUM_H-1)
//  NUM_ROUNDS 64   K words fetched per block (K_ADDR 0..NUM_ROUNDS-1)
//  RD_LAT     1    cycles from address change to RAM_DR sample; legal range 1..3
// PORTS
//  CLK         in   1   system clock; all logic on posedge
//  RST         in   1   reset, synchronous, active-high
//  START       in   1   1-cycle pulse: begin one H+K fetch sequence
//  ABORT       in   1   drop the current sequence, return to IDLE
//  MEM_RDY     in   1   H/K memory finished its ROM copy (memory RDY)
//  MEM_DR      in   32  memory read data (RAM_DR)
//  HK_SELECTOR out  1   0 = H region, 1 = K region
//  H_ADDR      out  3   H word address
//  K_ADDR      out  6   K word address
//  OUT_VALID   out  1   OUT_DATA holds a word not yet accepted
//  OUT_READY   in   1   core accepts the word when OUT_VALID & OUT_READY at posedge
//  OUT_DATA    out  32  fetched word
//  OUT_IS_K    out  1   0 = OUT_DATA is an H word, 1 = it is a K word
//  OUT_IDX     out  6   H index (0..7) or round index (0..63)
//  BUSY        out  1   high in every state except IDLE
//  DONE        out  1   1-cycle pulse after the last K word is accepted
// BEHAVIOUR
//  Reset: state IDLE. OUT_VALID, BUSY, DONE, HK_SELECTOR = 0. H_ADDR, K_ADDR, OUT_IDX = 0.
//    OUT_DATA = 0. OUT_IS_K = 0.
//  Reset mid-sequence: same values in the next cycle. The index is not retained.
//  States: IDLE -> WAIT_MEM -> ISSUE -> WAIT_DATA -> HOLD -> (ISSUE | FINISH) -> IDLE.
//  IDLE: START=1 moves to WAIT_MEM. START in any other state is ignored.
//  WAIT_MEM: stay until MEM_RDY=1, then go to ISSUE. If MEM_RDY is already 1, WAIT_MEM still lasts 1 cycle.
//  ISSUE: drive the address for the current item, then load the latency counter with RD_LAT-1.
//    H items: HK_SELECTOR=0, H_ADDR=idx.
//    K items: HK_SELECTOR=1, K_ADDR=idx.
//  Address and selector are registered. They hold stable from ISSUE until the word is accepted.
//  WAIT_DATA: decrement the counter each cycle. At 0, capture MEM_DR into OUT_DATA,
//    set OUT_VALID=1, go to HOLD.
//  One read is outstanding at a time: exactly 1 ISSUE per word.
//  HOLD: OUT_DATA, OUT_IDX and OUT_IS_K are frozen while OUT_VALID=1 and OUT_READY=0.
//  On accept: OUT_VALID=0 next cycle, then:
//    H idx < NUM_H-1: idx+1, go to ISSUE.
//    idx = NUM_H-1: switch to the K phase, idx=0, go to ISSUE.
//    K idx < NUM_ROUNDS-1: idx+1, go to ISSUE.
//    K idx = NUM_ROUNDS-1: go to FINISH.
//  Throughput: with OUT_READY tied to 1, one word per RD_LAT+2 cycles.
//    START to DONE = 1 + 72*(RD_LAT+2) + 1 cycles.
//  FINISH: DONE=1 for exactly 1 cycle, BUSY=0 next cycle, state IDLE.
//    START in the FINISH cycle is ignored.
//  ABORT: from any non-IDLE state, go to IDLE next cycle. OUT_VALID=0, DONE stays 0.
//    ABORT wins over a same-cycle accept. ABORT in IDLE has no effect.
//  If MEM_RDY drops mid-sequence: no effect. The memory only drops RDY on its own reset,
//    which is handled by the system-level RST.
//  Index counter is 7 bits wide internally. OUT_IDX carries its low 6 bits; no wrap is ever reachable.
// STRUCTURE
//  Shared include (with the other SHA-256 blocks): localparams HSEL=0, KSEL=1, SHA_NUM_H=8,
//    SHA_NUM_ROUNDS=64, and the state encodings.
//  Optional sub-module hk_lat_counter: small down-counter for the RD_LAT wait.
//  Everything else is one FSM plus registers in this module.
// TESTING
//  1 MEM_RDY=1, START, OUT_READY=1, RD_LAT=1 -> 72 words in order: H0=6a09e667 ... H7=5be0cd19,
//    K0=428a2f98 ... K63=c67178f2. DONE pulses 1 cycle, 218 cycles after START.
//  2 MEM_RDY=0 for 500 cycles, START, then MEM_RDY rises -> HK_SELECTOR/addresses do not change
//    before MEM_RDY rises. The first ISSUE is 1 cycle after MEM_RDY rises.
//  3 OUT_READY random at 30% -> OUT_DATA/OUT_IDX stable whenever valid & !ready.
//    Same 72-word stream as test 1. No word lost or duplicated.
//  4 ABORT during K idx 20 with valid=1, ready=1 -> IDLE next cycle, no DONE, OUT_VALID=0.
//    A new START then restarts at H0.
//  5 RST at H idx 5, then START -> all outputs at reset values, then the sequence restarts at H0.
//    START pulsed while BUSY is ignored.
//  6 RD_LAT=3 -> MEM_DR sampled exactly 3 cycles after the address changes
//    (bench memory model returns X before that). DONE 362 cycles after START.

Source files
------------

// File: rtl/hk_fetch_sequencer_pkg.sv
// hk_fetch_sequencer_pkg: shared SHA-256 H/K constants and fetch FSM encoding
package hk_fetch_sequencer_pkg;
  localparam logic HSEL = 1'b0;
  localparam logic KSEL = 1'b1;
  localparam int SHA_NUM_H = 8;
  localparam int SHA_NUM_ROUNDS = 64;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_MEM,
    S_ISSUE,
    S_WAIT_DATA,
    S_HOLD,
    S_FINISH
  } state_t;
endpackage

// File: rtl/hk_fetch_sequencer_lat_counter.sv
// hk_lat_counter: down-counter timing the memory read latency
module hk_lat_counter (
  input  logic       CLK,
  input  logic       RST,
  input  logic       load,
  input  logic [1:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [1:0] cnt;
  always_ff @(posedge CLK) begin
    if (RST) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != 2'd0) cnt <= cnt - 2'd1;
  end
  assign zero = cnt == 2'd0;
endmodule

// File: rtl/hk_fetch_sequencer.sv
// hk_fetch_sequencer: streams the 8 H words then 64 K constants from H/K memory to the round core
module hk_fetch_sequencer
  import hk_fetch_sequencer_pkg::*;
#(
  parameter int NUM_H      = SHA_NUM_H,
  parameter int NUM_ROUNDS = SHA_NUM_ROUNDS,
  parameter int RD_LAT     = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        ABORT,
  input  logic        MEM_RDY,
  input  logic [31:0] MEM_DR,
  output logic        HK_SELECTOR,
  output logic [2:0]  H_ADDR,
  output logic [5:0]  K_ADDR,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_DATA,
  output logic        OUT_IS_K,
  output logic [5:0]  OUT_IDX,
  output logic        BUSY,
  output logic        DONE
);
  state_t state, state_nxt;
  logic [6:0] idx;
  logic is_k, lat_zero, accept, last;
  assign accept = state == S_HOLD && OUT_READY && !ABORT;
  assign last = is_k && idx == 7'(NUM_ROUNDS - 1);
  hk_lat_counter u_lat (
    .CLK(CLK),
    .RST(RST),
    .load(state == S_ISSUE),
    .load_val(2'(RD_LAT - 1)),
    .dec(state == S_WAIT_DATA),
    .zero(lat_zero)
  );
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      state_nxt = START ? S_WAIT_MEM : S_IDLE;
      S_WAIT_MEM:  state_nxt = MEM_RDY ? S_ISSUE : S_WAIT_MEM;
      S_ISSUE:     state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: state_nxt = lat_zero ? S_HOLD : S_WAIT_DATA;
      S_HOLD:      state_nxt = OUT_READY ? (last ? S_FINISH : S_ISSUE) : S_HOLD;
      S_FINISH:    state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
    if (ABORT && state != S_IDLE) state_nxt = S_IDLE;
  end
  always_comb begin
    OUT_VALID = state == S_HOLD;
    BUSY = state != S_IDLE;
    DONE = state == S_FINISH;
  end
  assign OUT_IS_K = is_k;
  assign OUT_IDX = idx[5:0];
  // address and selector only move in ISSUE, so they stay put until the word is accepted
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx <= '0;
      is_k <= 1'b0;
      HK_SELECTOR <= HSEL;
      H_ADDR <= '0;
      K_ADDR <= '0;
      OUT_DATA <= '0;
    end else begin
      if (state == S_IDLE && START) begin
        idx <= '0;
        is_k <= 1'b0;
      end
      if (state == S_ISSUE) begin
        HK_SELECTOR <= is_k ? KSEL : HSEL;
        if (is_k) K_ADDR <= idx[5:0];
        else H_ADDR <= idx[2:0];
      end
      if (state == S_WAIT_DATA && lat_zero) OUT_DATA <= MEM_DR;
      if (accept) begin
        is_k <= is_k || idx == 7'(NUM_H - 1);
        idx <= !is_k && idx == 7'(NUM_H - 1) ? 7'd0 : idx + 7'd1;
      end
    end
  end
endmodule

// File: tb/tb_hk_fetch_sequencer.sv
// tb_hk_fetch_sequencer: scoreboard bench for the H/K fetch sequencer at RD_LAT 1 and 3
module tb_hk_fetch_sequencer;
  logic CLK = 1'b0, RST = 1'b1, ABORT = 1'b0, MEM_RDY = 1'b1;
  logic fixed_ready = 1'b1, rnd_ready = 1'b0, rnd = 1'b0, cur = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic OUT_READY;
  int vecs = 0, errs = 0, cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, done_base = 0;
  logic [38:0] q[$];
  logic hold_pend = 1'b0;
  logic [38:0] held = '0;
  logic [31:0] rom [72] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19,
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  always #5 CLK = ~CLK;
  assign OUT_READY = rnd ? rnd_ready : fixed_ready;
  always @(posedge CLK) cyc++;
  always @(posedge CLK) begin
    #1;
    rnd_ready = $urandom_range(0, 99) < 30;
  end
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = g == 0 ? 1 : 3;
    logic sel_o, valid, isk_o, busy_o, done_o;
    logic [2:0] ha_o;
    logic [5:0] ka_o, idx_o;
    logic [31:0] dr = 32'hdeadbeef, data;
    logic [6:0] prev = 7'h7f, a;
    int age = 0;
    hk_fetch_sequencer #(.RD_LAT(LAT)) dut (
      .CLK(CLK), .RST(RST), .START(g == 0 ? start0 : start1), .ABORT(ABORT), .MEM_RDY(MEM_RDY),
      .MEM_DR(dr), .HK_SELECTOR(sel_o), .H_ADDR(ha_o), .K_ADDR(ka_o), .OUT_VALID(valid),
      .OUT_READY(OUT_READY), .OUT_DATA(data), .OUT_IS_K(isk_o), .OUT_IDX(idx_o), .BUSY(busy_o), .DONE(done_o)
    );
    // memory model: poison data until LAT edges have passed since the address last moved
    always @(negedge CLK) begin
      a = sel_o ? 7'd8 + {1'b0, ka_o} : {4'd0, ha_o};
      if (a != prev) begin
        prev = a;
        age = 0;
      end else if (age < 8) age++;
      dr = age >= LAT - 1 ? rom[a] : 32'hdeadbeef;
    end
  end
  logic v, isk, bsy, dn, sel;
  logic [2:0] ha;
  logic [5:0] ka, idxo;
  logic [31:0] dat;
  assign v = cur ? u[1].valid : u[0].valid;
  assign isk = cur ? u[1].isk_o : u[0].isk_o;
  assign bsy = cur ? u[1].busy_o : u[0].busy_o;
  assign dn = cur ? u[1].done_o : u[0].done_o;
  assign sel = cur ? u[1].sel_o : u[0].sel_o;
  assign ha = cur ? u[1].ha_o : u[0].ha_o;
  assign ka = cur ? u[1].ka_o : u[0].ka_o;
  assign idxo = cur ? u[1].idx_o : u[0].idx_o;
  assign dat = cur ? u[1].data : u[0].data;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge CLK) begin
    if (v && OUT_READY && !RST && !ABORT) begin
      if (q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL extra_word: got %0h expected none", {isk, idxo, dat});
      end else chk("word", {isk, idxo, dat}, q.pop_front());
    end
    if (hold_pend && v) chk("hold_stable", {isk, idxo, dat}, held);
    hold_pend = v && !OUT_READY && !RST && !ABORT;
    held = {isk, idxo, dat};
    if (dn) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic push_seq();
    for (int i = 0; i < 72; i++) q.push_back({i >= 8 ? 1'b1 : 1'b0, i >= 8 ? 6'(i - 8) : 6'(i), rom[i]});
  endtask
  task automatic pulse_start(input logic g);
    done_base = done_cnt;
    start_cyc = cyc;
    if (g) start1 = 1'b1;
    else start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask
  task automatic wait_done(input int exp_lat);
    int n = 0;
    while (done_cnt == done_base && n < 5000) begin
      tick(1);
      n++;
    end
    chk("done_seen", 64'(done_cnt != done_base), 1);
    if (exp_lat > 0) chk("done_latency", 64'(done_cyc - start_cyc), 64'(exp_lat));
    tick(2);
    chk("done_pulses", 64'(done_cnt - done_base), 1);
    chk("idle_after_done", {bsy, v}, 0);
    chk("all_words_out", 64'(q.size()), 0);
  endtask
  task automatic wait_word(input logic k, input int i);
    int n = 0;
    while (!(v && isk == k && idxo == 6'(i)) && n < 2000) begin
      tick(1);
      n++;
    end
    chk("reach_word", {v, isk, idxo}, {1'b1, k, 6'(i)});
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic moved;
    tick(3);
    chk("reset_state", {v, bsy, dn, sel, ha, ka, idxo, dat, isk}, 0);
    RST = 1'b0;
    tick(2);
    push_seq();
    pulse_start(0);
    wait_done(218);
    MEM_RDY = 1'b0;
    tick(20);
    push_seq();
    pulse_start(0);
    moved = 1'b0;
    repeat (500) begin
      tick(1);
      if ({sel, ha, ka} != {1'b1, 3'd7, 6'd63}) moved = 1'b1;
    end
    chk("no_addr_before_rdy", moved, 0);
    chk("busy_wait_mem", {bsy, v}, 2'b10);
    MEM_RDY = 1'b1;
    tick(1);
    chk("addr_held_issue", {sel, ha, ka}, {1'b1, 3'd7, 6'd63});
    tick(1);
    chk("first_issue_addr", {sel, ha}, 0);
    wait_done(-1);
    rnd = 1'b1;
    push_seq();
    pulse_start(0);
    wait_done(-1);
    rnd = 1'b0;
    push_seq();
    pulse_start(0);
    wait_word(1'b1, 20);
    ABORT = 1'b1;
    tick(1);
    ABORT = 1'b0;
    chk("abort_idle", {v, bsy, dn}, 0);
    chk("abort_remaining", 64'(q.size()), 44);
    q.delete();
    tick(5);
    chk("abort_no_done", 64'(done_cnt - done_base), 0);
    push_seq();
    pulse_start(0);
    wait_done(218);
    push_seq();
    pulse_start(0);
    wait_word(1'b0, 5);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    chk("reset_mid", {v, bsy, dn, sel, ha, ka, idxo, dat, isk}, 0);
    chk("reset_remaining", 64'(q.size()), 67);
    q.delete();
    push_seq();
    pulse_start(0);
    tick(30);
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    wait_done(218);
    cur = 1'b1;
    tick(2);
    push_seq();
    pulse_start(1);
    wait_done(362);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
